// File: rtl/anim_sprite_engine.sv
// -----------------------------------------------------------------------------
// anim_sprite_engine
//
// Maps the beam position to a sprite-local pixel and drives a sprite-ROM
// address {frame_idx, row, column}. The animation frame sequences on its own
// from video-frame ticks in loop, ping-pong, one-shot or hold mode. Supports
// per-axis flip and integer down-scaling of beam coordinates.
//
// Pipeline: stage 0 geometry (comb) -> stage 1 rom_addr/box -> stage 2 col/active.
// Latency from hpos/vpos to col/active is two clocks.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   hpos, vpos          beam position (unscaled)
//   frame_tick          one-cycle pulse per video frame
//   xpos, ypos          sprite top-left corner in scaled coordinates
//   mode                0 loop, 1 ping-pong, 2 one-shot, 3 hold
//   hflip, vflip        mirror column / row
//   restart             synchronous animation restart (wins over frame_tick)
//   rom_addr            {frame_idx, row, column} or 0 outside the box
//   rom_bit             ROM pixel for rom_addr (combinational from the ROM)
//   col                 pixel colour, 0 = transparent
//   active              beam inside sprite box, aligned with col
//   frame_idx           current animation frame
//   anim_done           one-shot finished, sticky until restart
// -----------------------------------------------------------------------------
module anim_sprite_engine #(
    parameter int         SIZE_BITS     = 4,
    parameter int         FRAME_BITS    = 2,
    parameter int         FRAME_LEN     = 4,
    parameter int         FRAME_TIME    = 30,
    parameter int         SCALE_SHIFT   = 1,
    parameter logic [2:0] PRIMARY_COLOR = 3'd1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [9:0]                        hpos,
    input  logic [9:0]                        vpos,
    input  logic                              frame_tick,
    input  logic [9:0]                        xpos,
    input  logic [9:0]                        ypos,
    input  logic [1:0]                        mode,
    input  logic                              hflip,
    input  logic                              vflip,
    input  logic                              restart,
    output logic [FRAME_BITS+2*SIZE_BITS-1:0] rom_addr,
    input  logic                              rom_bit,
    output logic [2:0]                        col,
    output logic                              active,
    output logic [FRAME_BITS-1:0]             frame_idx,
    output logic                              anim_done
);

    localparam int                    SIZE    = 1 << SIZE_BITS;
    localparam logic [FRAME_BITS-1:0] LAST    = FRAME_BITS'(FRAME_LEN - 1);
    localparam logic [7:0]            T_LAST  = 8'(FRAME_TIME - 1);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    // ---------------- stage 0: geometry ----------------
    logic [9:0]           hs, vs;
    logic [10:0]          dx, dy;
    logic                 in_box;
    logic [SIZE_BITS-1:0] column, row;

    assign hs = hpos >> SCALE_SHIFT;
    assign vs = vpos >> SCALE_SHIFT;
    // 11-bit difference of zero-extended operands; bit 10 set means negative.
    assign dx = {1'b0, hs} - {1'b0, xpos};
    assign dy = {1'b0, vs} - {1'b0, ypos};
    assign in_box = !dx[10] && (dx[9:0] < 10'(SIZE)) &&
                    !dy[10] && (dy[9:0] < 10'(SIZE));
    // SIZE-1-d modulo SIZE is the bitwise inverse of the low bits.
    assign column = hflip ? ~dx[SIZE_BITS-1:0] : dx[SIZE_BITS-1:0];
    assign row    = vflip ? ~dy[SIZE_BITS-1:0] : dy[SIZE_BITS-1:0];

    // ---------------- animation sequencer ----------------
    logic [FRAME_BITS-1:0] idx_reg, idx_next;
    logic [7:0]            cnt_reg, cnt_next;
    dir_t                  dir_reg, dir_next;
    logic                  done_reg, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg  <= '0;
            cnt_reg  <= '0;
            dir_reg  <= DIR_UP;
            done_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            cnt_reg  <= cnt_next;
            dir_reg  <= dir_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        idx_next  = idx_reg;
        cnt_next  = cnt_reg;
        dir_next  = dir_reg;
        done_next = done_reg;
        if (restart) begin
            idx_next  = '0;
            cnt_next  = '0;
            dir_next  = DIR_UP;
            done_next = 1'b0;
        end else if (frame_tick && mode != 2'd3) begin
            if (cnt_reg >= T_LAST) begin
                cnt_next = '0;
                case (mode)
                    2'd0: begin
                        dir_next = DIR_UP;
                        idx_next = (idx_reg == LAST) ? '0 : idx_reg + 1'b1;
                    end
                    2'd1: begin
                        if (FRAME_LEN == 1) begin
                            idx_next = '0;
                        end else if (dir_reg == DIR_UP) begin
                            if (idx_reg == LAST) begin
                                dir_next = DIR_DOWN;
                                idx_next = idx_reg - 1'b1;
                            end else begin
                                idx_next = idx_reg + 1'b1;
                            end
                        end else begin
                            if (idx_reg == '0) begin
                                dir_next = DIR_UP;
                                idx_next = idx_reg + 1'b1;
                            end else begin
                                idx_next = idx_reg - 1'b1;
                            end
                        end
                    end
                    default: begin
                        // one-shot: done is raised in the cycle the last
                        // frame is reached (or at once when already there)
                        dir_next = DIR_UP;
                        if (idx_reg == LAST) begin
                            done_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                            if (idx_reg + 1'b1 == LAST)
                                done_next = 1'b1;
                        end
                    end
                endcase
            end else begin
                cnt_next = cnt_reg + 8'd1;
            end
        end
    end

    assign frame_idx = idx_reg;
    assign anim_done = done_reg;

    // ---------------- stage 1 / stage 2 ----------------
    logic box_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            box_q    <= 1'b0;
            col      <= 3'd0;
            active   <= 1'b0;
        end else begin
            rom_addr <= in_box ? {idx_reg, row, column} : '0;
            box_q    <= in_box;
            col      <= (box_q && rom_bit) ? PRIMARY_COLOR : 3'd0;
            active   <= box_q;
        end
    end

endmodule

// File: tb/tb_anim_sprite_engine.sv
// Scoreboard bench for anim_sprite_engine. Stimulus pushes expected pixel and
// sequencer results into queues; a negedge monitor pops and compares them.
module tb_anim_sprite_engine;

    localparam int SB   = 4;
    localparam int FB   = 2;
    localparam int LEN  = 3;
    localparam int FT   = 2;
    localparam int SS   = 1;
    localparam int SIZE = 1 << SB;
    localparam int AW   = FB + 2 * SB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    hpos = '0, vpos = '0, xpos = '0, ypos = '0;
    logic          frame_tick = 1'b0, hflip = 1'b0, vflip = 1'b0, restart = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] rom_addr;
    logic          rom_bit;
    logic [2:0]    col;
    logic          active;
    logic [FB-1:0] frame_idx;
    logic          anim_done;

    always #5 clk = ~clk;

    anim_sprite_engine #(
        .SIZE_BITS(SB), .FRAME_BITS(FB), .FRAME_LEN(LEN), .FRAME_TIME(FT),
        .SCALE_SHIFT(SS), .PRIMARY_COLOR(3'd1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .frame_tick(frame_tick), .xpos(xpos), .ypos(ypos), .mode(mode),
        .hflip(hflip), .vflip(vflip), .restart(restart), .rom_addr(rom_addr),
        .rom_bit(rom_bit), .col(col), .active(active), .frame_idx(frame_idx),
        .anim_done(anim_done)
    );

    // sprite ROM model
    logic rom_tab [0:(1<<AW)-1];
    assign rom_bit = rom_tab[rom_addr];

    typedef struct { int due; int addr; int idx; int done; } s1_t;
    typedef struct { int due; int colv; int act; } s2_t;
    typedef struct { string name; int act; int exp; } imm_t;
    s1_t  q1[$];
    s2_t  q2[$];
    imm_t q0[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference sequencer state
    int m_idx = 0, m_cnt = 0, m_dir = 1, m_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_imm(input string name, input int act, input int exp);
        imm_t i;
        i.name = name; i.act = act; i.exp = exp;
        q0.push_back(i);
    endtask

    // monitor
    always @(negedge clk) begin
        imm_t i0; s1_t e1; s2_t e2;
        while (q0.size() > 0) begin
            i0 = q0.pop_front();
            check(i0.name, i0.act, i0.exp);
        end
        if (reset_n) begin
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e1 = q1.pop_front();
                check("rom_addr",  int'(rom_addr),  e1.addr);
                check("frame_idx", int'(frame_idx), e1.idx);
                check("anim_done", int'(anim_done), e1.done);
            end
            while (q2.size() > 0 && q2[0].due <= cyc) begin
                e2 = q2.pop_front();
                check("active", int'(active), e2.act);
                check("col",    int'(col),    e2.colv);
                $display("txn cyc=%0d addr=%0d col=%0d active=%0d idx=%0d done=%0d",
                         cyc, rom_addr, col, active, frame_idx, anim_done);
            end
        end
    end

    // one advance of the reference sequencer, straight from the mode rules
    task automatic seq_step(input int md, input bit ft, input bit rs);
        if (rs) begin
            m_idx = 0; m_cnt = 0; m_dir = 1; m_done = 0;
        end else if (ft && md != 3) begin
            m_cnt++;
            if (m_cnt == FT) begin
                m_cnt = 0;
                if (md == 0) begin
                    m_dir = 1;
                    m_idx = (m_idx + 1) % LEN;
                end else if (md == 1) begin
                    if (LEN > 1) begin
                        if (m_idx + m_dir < 0 || m_idx + m_dir > LEN - 1) m_dir = -m_dir;
                        m_idx = m_idx + m_dir;
                    end
                end else begin
                    m_dir = 1;
                    if (m_idx < LEN - 1) m_idx++;
                    if (m_idx == LEN - 1) m_done = 1;
                end
            end
        end
    endtask

    task automatic drive(input int h, input int v, input int x, input int y,
                         input bit hf, input bit vf, input int md,
                         input bit ft, input bit rs);
        int dx, dy, c, r, a;
        bit inb;
        s1_t e1; s2_t e2;
        @(posedge clk); #1;
        hpos = 10'(h); vpos = 10'(v); xpos = 10'(x); ypos = 10'(y);
        hflip = hf; vflip = vf; mode = 2'(md); frame_tick = ft; restart = rs;
        dx = (h >> SS) - x;
        dy = (v >> SS) - y;
        inb = (dx >= 0) && (dx < SIZE) && (dy >= 0) && (dy < SIZE);
        c = hf ? SIZE - 1 - dx : dx;
        r = vf ? SIZE - 1 - dy : dy;
        a = inb ? (m_idx * SIZE * SIZE + r * SIZE + c) : 0;
        e1.due = cyc + 1; e1.addr = a;
        seq_step(md, ft, rs);
        e1.idx = m_idx; e1.done = m_done;
        q1.push_back(e1);
        e2.due = cyc + 2; e2.act = inb ? 1 : 0;
        e2.colv = (inb && rom_tab[a] == 1'b1) ? 1 : 0;
        q2.push_back(e2);
    endtask

    task automatic rand_pixel(input int md, input bit ft, input bit rs);
        int x, y, h, v;
        x = $urandom_range(0, 480);
        y = $urandom_range(0, 480);
        if ($urandom_range(0, 7) == 0) begin
            h = $urandom_range(0, 1023);
            v = $urandom_range(0, 1023);
        end else begin
            h = 2 * (x + $urandom_range(0, SIZE + 5) - 3) + $urandom_range(0, 1);
            v = 2 * (y + $urandom_range(0, SIZE + 5) - 3) + $urandom_range(0, 1);
        end
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        drive(h, v, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), md, ft, rs);
    endtask

    initial begin
        int cur_md;
        for (int k = 0; k < (1 << AW); k++) rom_tab[k] = 1'($urandom_range(0, 1));
        rom_tab[0]     = 1'b0;
        rom_tab[15]    = 1'b1;
        rom_tab[8'hFF] = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        push_imm("reset_rom_addr",  int'(rom_addr),  0);
        push_imm("reset_col",       int'(col),       0);
        push_imm("reset_active",    int'(active),    0);
        push_imm("reset_frame_idx", int'(frame_idx), 0);
        push_imm("reset_anim_done", int'(anim_done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // geometry boundaries and flips
        drive(20, 40, 10, 20, 0, 0, 0, 0, 0);   // dx=dy=0
        drive(19, 40, 10, 20, 0, 0, 0, 0, 0);   // dx=-1
        drive(51, 40, 10, 20, 0, 0, 0, 0, 0);   // dx=15
        drive(52, 40, 10, 20, 0, 0, 0, 0, 0);   // dx=16
        drive(20, 71, 10, 20, 0, 0, 0, 0, 0);   // dy=15
        drive(20, 72, 10, 20, 0, 0, 0, 0, 0);   // dy=16
        drive(20, 40, 10, 20, 1, 1, 0, 0, 0);   // flipped corner -> row 15 col 15
        drive(21, 41, 10, 20, 1, 0, 0, 0, 0);

        // loop
        drive(0, 0, 600, 600, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) drive(0, 0, 600, 600, 0, 0, 0, 1, 0);
        // ping-pong
        drive(0, 0, 600, 600, 0, 0, 1, 0, 1);
        for (int k = 0; k < 16; k++) drive(0, 0, 600, 600, 0, 0, 1, 1, 0);
        // one-shot, then restart colliding with a tick
        drive(0, 0, 600, 600, 0, 0, 2, 0, 1);
        for (int k = 0; k < 10; k++) drive(0, 0, 600, 600, 0, 0, 2, 1, 0);
        drive(0, 0, 600, 600, 0, 0, 2, 1, 1);
        drive(0, 0, 600, 600, 0, 0, 2, 1, 0);
        // hold
        for (int k = 0; k < 4; k++) drive(0, 0, 600, 600, 0, 0, 3, 1, 0);

        // randomized traffic with mode changes
        cur_md = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 31) == 0) cur_md = $urandom_range(0, 3);
            rand_pixel(cur_md, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        end

        // asynchronous reset with a nonzero frame and an active pixel
        for (int k = 0; k < 12 && m_idx == 0; k++) drive(0, 0, 600, 600, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) drive(20, 40, 10, 20, 0, 0, 3, 0, 0);
        @(posedge clk); #3;
        push_imm("pre_reset_active", int'(active),    1);
        push_imm("pre_reset_idx",    int'(frame_idx), m_idx);
        reset_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        push_imm("async_rst_col",       int'(col),       0);
        push_imm("async_rst_active",    int'(active),    0);
        push_imm("async_rst_rom_addr",  int'(rom_addr),  0);
        push_imm("async_rst_frame_idx", int'(frame_idx), 0);
        push_imm("async_rst_anim_done", int'(anim_done), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_idx = 0; m_cnt = 0; m_dir = 1; m_done = 0;

        drive(20, 40, 10, 20, 0, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 31) == 0) cur_md = $urandom_range(0, 3);
            rand_pixel(cur_md, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        end

        repeat (4) @(posedge clk);
        #1;
        push_imm("q1_drained", q1.size(), 0);
        push_imm("q2_drained", q2.size(), 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
